// File: rtl/timer_counter.sv
// Memory-mapped programmable down-counter with a one-shot or auto-reload interrupt.
// Optional prescaler on offset 3 is enabled by defining TIMER_PRESCALE_EN.
module timer_counter #(
    parameter int COUNT_W             = 32,
    parameter bit HALT_ON_ZERO_PRESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [3:0]  be,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } ctrl_t;

    function automatic logic [31:0] byte_merge(input logic [31:0] old,
                                               input logic [31:0] wd,
                                               input logic [3:0]  b);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (b[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    state_t               state_q, state_d;
    ctrl_t                ctrl_q, ctrl_d, ctrl_w;
    logic [COUNT_W-1:0]   preset_q, preset_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic                 flag_q, flag_d;
    logic                 irq_q, irq_d;
    logic                 tick;
    logic                 wr_any, ctrl_wr, preset_wr;
    logic [31:0]          preset_rd, count_rd, preset_merged, psc_rd;

    assign wr_any    = we && (be != 4'b0000);
    assign ctrl_wr   = wr_any && (addr == 2'd0);
    assign preset_wr = wr_any && (addr == 2'd1);

    always_comb begin
        preset_rd = '0;
        preset_rd[COUNT_W-1:0] = preset_q;
        count_rd = '0;
        count_rd[COUNT_W-1:0] = count_q;
    end

    assign preset_merged = byte_merge(preset_rd, din, be);
    assign preset_d      = preset_wr ? preset_merged[COUNT_W-1:0] : preset_q;

    // CTRL fields live in byte 0; a write with only upper byte enables still
    // counts as a CTRL write for flag clearing.
    always_comb begin
        ctrl_w = ctrl_q;
        if (ctrl_wr && be[0]) ctrl_w = ctrl_t'(din[3:0]);
    end

    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_w;
        count_d = count_q;
        flag_d  = flag_q;

        case (state_q)
            S_IDLE: if (ctrl_w.en) state_d = S_LOAD;
            S_LOAD: begin
                count_d = preset_q;
                if (HALT_ON_ZERO_PRESET && (preset_q == '0)) state_d = S_INT;
                else                                         state_d = S_CNT;
            end
            S_CNT: begin
                if (tick) begin
                    if (count_q == '0) state_d = S_INT;
                    else               count_d = count_q - COUNT_W'(1);
                end
            end
            S_INT: begin
                if (ctrl_w.mode == 2'd1) begin
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                    if (!ctrl_wr) ctrl_d.en = 1'b0;
                end
            end
        endcase

        // Disabling via CTRL aborts from any state and freezes COUNT.
        if (ctrl_wr && !ctrl_w.en) begin
            state_d = S_IDLE;
            count_d = count_q;
        end

        if (ctrl_wr)
            flag_d = 1'b0;
        else if ((state_d == S_INT) && (state_q != S_INT))
            flag_d = 1'b1;
        else if ((state_q == S_INT) && (ctrl_w.mode == 2'd1))
            flag_d = 1'b0;

        irq_d = ctrl_d.im & flag_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            flag_q   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            flag_q   <= flag_d;
            irq_q    <= irq_d;
        end
    end

`ifdef TIMER_PRESCALE_EN
    logic [15:0] psc_cnt_q, psc_cnt_d;
    logic [15:0] psc_val_q, psc_val_d;
    logic        tick_q, tick_d;
    logic        psc_wr;

    assign psc_wr = wr_any && (addr == 2'd3);

    always_comb begin
        psc_val_d = psc_val_q;
        if (psc_wr && be[0]) psc_val_d[7:0]  = din[7:0];
        if (psc_wr && be[1]) psc_val_d[15:8] = din[15:8];
    end

    // The tick is registered off the prescaler wrap, so the first decrement
    // lands PRESCALE+2 clocks into CNT and then every PRESCALE+1 clocks.
    always_comb begin
        psc_cnt_d = psc_cnt_q;
        tick_d    = 1'b0;
        if (state_q == S_LOAD) begin
            psc_cnt_d = '0;
        end else if (state_q == S_CNT) begin
            if (psc_cnt_q == psc_val_q) begin
                psc_cnt_d = '0;
                tick_d    = 1'b1;
            end else begin
                psc_cnt_d = psc_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            psc_cnt_q <= '0;
            psc_val_q <= '0;
            tick_q    <= 1'b0;
        end else begin
            psc_cnt_q <= psc_cnt_d;
            psc_val_q <= psc_val_d;
            tick_q    <= tick_d;
        end
    end

    assign tick   = tick_q;
    assign psc_rd = {16'b0, psc_val_q};
`else
    assign tick   = 1'b1;
    assign psc_rd = '0;
`endif

    always_comb begin
        case (addr)
            2'd0:    dout = {28'b0, ctrl_q};
            2'd1:    dout = preset_rd;
            2'd2:    dout = count_rd;
            default: dout = psc_rd;
        endcase
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed steps plus randomized trials
// compared against timing formulas derived from the counter's rules.
module tb_timer_counter;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    int n_assert = 0;
    int n_fail   = 0;

    timer_counter dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .be    (be),
        .din   (din),
        .dout  (dout),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [3:0] b, input logic [31:0] d);
        addr = a; be = b; din = d; we = 1'b1;
        step();
        we = 1'b0; be = 4'b0000;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        addr = a;
        #1;
        v = dout;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Edge k counts from the edge that sampled the enabling CTRL write (k=0).
    function automatic logic exp_irq(int p, int mode, bit im, int k);
        if (k < 2 + p) return 1'b0;
        if (mode == 1) return im && (((k - 2 - p) % (p + 3)) == 0);
        return im;
    endfunction

    function automatic logic [31:0] exp_cnt(int p, int mode, int k);
        int ph;
        ph = (mode == 1) ? (k - 1) % (p + 3) : (k - 1);
        return (ph >= p) ? 32'd0 : 32'(p - ph);
    endfunction

    initial begin
        logic [31:0] rv, pmodel, d, mask;
        logic [3:0]  b;
        int          p, mode, cycles;
        bit          im, seen;

        reset = 1'b0; addr = 2'd0; we = 1'b0; be = 4'b0000; din = '0;
        repeat (3) step();
        chk("irq_in_reset", {31'b0, irq}, 32'd0);
        reset = 1'b1;
        for (int a = 0; a < 4; a++) begin
            rd(a[1:0], rv);
            chk($sformatf("reset_read_%0d", a), rv, 32'd0);
        end
        chk("irq_after_reset", {31'b0, irq}, 32'd0);

        wr(2'd1, 4'b0011, 32'h1234_5678);
        rd(2'd1, rv); chk("preset_be0011", rv, 32'h0000_5678);
        pmodel = 32'h0000_5678;
        wr(2'd2, 4'b1111, 32'hDEAD_BEEF);
        rd(2'd2, rv); chk("count_ro", rv, 32'd0);
        wr(2'd3, 4'b1111, 32'hCAFE_BEEF);
        rd(2'd3, rv);
`ifdef TIMER_PRESCALE_EN
        chk("prescale_rw", rv, 32'h0000_BEEF);
`else
        chk("offset3_zero", rv, 32'd0);
`endif
        wr(2'd3, 4'b1111, 32'd0);

        for (int i = 0; i < 4; i++) begin
            d = $urandom;
            b = 4'($urandom_range(0, 15));
            mask = '0;
            for (int j = 0; j < 4; j++) if (b[j]) mask[8*j +: 8] = 8'hFF;
            pmodel = (pmodel & ~mask) | (d & mask);
            wr(2'd1, b, d);
            rd(2'd1, rv); chk($sformatf("preset_merge_%0d", i), rv, pmodel);
        end

        // One-shot, PRESET=5.
        wr(2'd1, 4'b1111, 32'd5);
        wr(2'd0, 4'b0001, 32'h9);
        for (int k = 1; k <= 27; k++) begin
            step();
            chk($sformatf("os_irq_k%0d", k), {31'b0, irq}, {31'b0, exp_irq(5, 0, 1'b1, k)});
            rd(2'd2, rv); chk($sformatf("os_cnt_k%0d", k), rv, exp_cnt(5, 0, k));
            if (k == 7) begin rd(2'd0, rv); chk("os_ctrl_k7", rv, 32'h9); end
            if (k == 8) begin rd(2'd0, rv); chk("os_ctrl_k8", rv, 32'h8); end
        end
        wr(2'd0, 4'b0001, 32'h8);
        chk("os_irq_cleared", {31'b0, irq}, 32'd0);

        // Auto-reload, PRESET=3; IM dropped mid-run at edge 21.
        wr(2'd1, 4'b1111, 32'd3);
        wr(2'd0, 4'b0001, 32'hB);
        for (int k = 1; k <= 45; k++) begin
            if (k == 21) begin addr = 2'd0; be = 4'b0001; din = 32'h3; we = 1'b1; end
            step();
            we = 1'b0; be = 4'b0000;
            chk($sformatf("ar_irq_k%0d", k), {31'b0, irq}, {31'b0, exp_irq(3, 1, k < 21, k)});
            rd(2'd2, rv); chk($sformatf("ar_cnt_k%0d", k), rv, exp_cnt(3, 1, k));
        end
        wr(2'd0, 4'b0001, 32'h0);

        // Randomized trials.
        for (int t = 0; t < 8; t++) begin
            p    = $urandom_range(1, 12);
            mode = $urandom_range(0, 3);
            im   = 1'($urandom_range(0, 1));
            wr(2'd1, 4'b1111, 32'(p));
            wr(2'd0, 4'b0001, 32'(int'(im) * 8 + mode * 2 + 1));
            cycles = 3 * (p + 3) + 4;
            for (int k = 1; k <= cycles; k++) begin
                step();
                chk($sformatf("rt%0d_irq_k%0d", t, k), {31'b0, irq}, {31'b0, exp_irq(p, mode, im, k)});
                rd(2'd2, rv); chk($sformatf("rt%0d_cnt_k%0d", t, k), rv, exp_cnt(p, mode, k));
            end
            rd(2'd0, rv);
            chk($sformatf("rt%0d_ctrl", t), rv, 32'(int'(im) * 8 + mode * 2 + (mode == 1 ? 1 : 0)));
            wr(2'd0, 4'b0001, 32'h0);
            chk($sformatf("rt%0d_irq_off", t), {31'b0, irq}, 32'd0);
        end

        // Abort at COUNT=40.
        wr(2'd1, 4'b1111, 32'd100);
        wr(2'd0, 4'b0001, 32'h9);
        repeat (61) step();
        rd(2'd2, rv); chk("abort_cnt40", rv, 32'd40);
        wr(2'd0, 4'b0001, 32'h8);
        seen = 1'b0;
        for (int k = 0; k < 120; k++) begin
            step();
            if (irq) seen = 1'b1;
        end
        rd(2'd2, rv); chk("abort_cnt_hold", rv, 32'd40);
        chk("abort_no_irq", {31'b0, seen}, 32'd0);
        rd(2'd0, rv); chk("abort_ctrl", rv, 32'h8);

        // CTRL write on the INT-entry edge (edge 4 for PRESET=2).
        wr(2'd1, 4'b1111, 32'd2);
        wr(2'd0, 4'b0001, 32'h9);
        repeat (3) step();
        wr(2'd0, 4'b0001, 32'hD);
        chk("coll_irq_e4", {31'b0, irq}, 32'd0);
        rd(2'd0, rv); chk("coll_ctrl_e4", rv, 32'hD);
        step();
        chk("coll_irq_e5", {31'b0, irq}, 32'd0);
        rd(2'd0, rv); chk("coll_ctrl_e5", rv, 32'hC);
        repeat (3) step();
        chk("coll_irq_later", {31'b0, irq}, 32'd0);
        wr(2'd0, 4'b0001, 32'h0);

        // Zero PRESET: interrupt straight after LOAD.
        wr(2'd1, 4'b1111, 32'd0);
        wr(2'd0, 4'b0001, 32'h9);
        chk("zp_irq_e0", {31'b0, irq}, 32'd0);
        step();
        chk("zp_irq_e1", {31'b0, irq}, 32'd1);
        wr(2'd0, 4'b0001, 32'h0);

        // Async reset while irq is high.
        wr(2'd1, 4'b1111, 32'd1);
        wr(2'd0, 4'b0001, 32'h9);
        repeat (3) step();
        chk("ar_pre_irq", {31'b0, irq}, 32'd1);
        #2 reset = 1'b0;
        #1 chk("arst_irq", {31'b0, irq}, 32'd0);
        rd(2'd2, rv); chk("arst_cnt", rv, 32'd0);
        rd(2'd1, rv); chk("arst_preset", rv, 32'd0);
        rd(2'd0, rv); chk("arst_ctrl", rv, 32'd0);
        reset = 1'b1;
        step();

`ifdef TIMER_PRESCALE_EN
        wr(2'd3, 4'b0011, 32'd1);
        wr(2'd1, 4'b1111, 32'd2);
        wr(2'd0, 4'b0001, 32'h9);
        for (int k = 1; k <= 10; k++) begin
            step();
            chk($sformatf("psc_irq_k%0d", k), {31'b0, irq}, {31'b0, k >= 8});
        end
        wr(2'd0, 4'b0001, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
- Memory-mapped programmable down-counter behind the system bridge.
- Written through the CPU's store path (address, write data, write enable, byte enables).
- Its interrupt request drives a CPU hardware-interrupt line (HWInt[2]).
- Provides the periodic and one-shot interrupts used to exercise the CP0 exception/eret path.

Parameters:
- COUNT_W, 32, width of PRESET and COUNT registers (1..32); upper bits read as 0.
- HALT_ON_ZERO_PRESET, 1, if 1, PRESET==0 with enable set raises the interrupt after LOAD without counting.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- addr  in  2  word offset within the block, i.e. bus address bits [3:2].
- we  in  1  write strobe from the bridge, sampled on clk rising edge.
- be  in  4  byte enables for the write; be[i] selects din[8i+7:8i].
- din  in  32  write data.
- dout  out  32  read data, combinational from addr.
- irq  out  1  interrupt request to CPU, registered.

Behaviour:
- Register map (word offsets):
  - 0 CTRL: [0] EN, [2:1] MODE, [3] IM; other bits read 0.
  - 1 PRESET: read/write.
  - 2 COUNT: read-only; writes ignored.
  - 3 PRESCALE (see optional feature).
- Writes merge byte-wise under be; be==0 is a no-op.
- Reset (reset=0, async): CTRL=0, PRESET=0, COUNT=0, state=IDLE, flag=0, irq=0.
- irq is a register: irq <= IM & flag_next.
- States:
  - IDLE: if EN go LOAD, else stay.
  - LOAD: COUNT<=PRESET; go CNT.
  - CNT: on a tick, if COUNT==0 go INT, else COUNT<=COUNT-1.
  - INT: flag set on entry. MODE 0 (one-shot): EN cleared, go IDLE. MODE 1 (auto-reload): go LOAD. MODE 2/3 behave as MODE 0.
- Interrupt flag:
  - MODE 0: flag stays 1 until any CTRL write (any be), including a write that re-enables.
  - MODE 1: flag is a one-cycle pulse, cleared on the edge leaving INT.
- Timing, MODE 1, P=PRESET, no prescale:
  - Write setting EN sampled at edge 0; LOAD after edge 0.
  - COUNT=P after edge 1; COUNT=0 after edge 1+P.
  - INT and irq=1 after edge 2+P.
  - Period between pulses is P+3 cycles.
- EN cleared by a CTRL write in any state: state -> IDLE at the same edge; COUNT holds its value.
- Simultaneous events:
  - CTRL write in the same cycle as an INT entry: the write wins for CTRL fields, and flag is cleared (write priority).
  - PRESET write during CNT: takes effect at the next LOAD only.
- COUNT never wraps: decrement stops at 0.
- PRESET wider than COUNT_W is truncated.
- Reset asserted mid-count: everything returns to reset values immediately; irq falls without waiting for clk.

Optional Feature:
- Macro TIMER_PRESCALE_EN.
- Defined:
  - Offset 3 is PRESCALE[15:0], reset 0, byte-writable.
  - An internal prescale counter generates a tick every PRESCALE+1 clocks while in CNT.
  - The prescale counter clears on LOAD.
- Undefined:
  - Every CNT cycle is a tick.
  - Offset 3 reads 0 and writes are ignored.

Test Plan:
- Reset/read-back: hold reset=0 then release; read offsets 0..3 -> all 0, irq=0. Write PRESET=0x12345678 with be=4'b0011 -> reads 0x00005678.
- One-shot: PRESET=5, CTRL=0x9 (EN, MODE0, IM) sampled at edge 0 -> irq=1 after edge 7. CTRL reads 0x8. irq stays 1 for 20 cycles. Writing CTRL=0x8 -> irq=0 next edge.
- Auto-reload: PRESET=3, CTRL=0xB (EN, MODE1, IM) -> irq 1-cycle pulses, 6 cycles apart, first after edge 5. CTRL=0x3 (IM=0) -> no pulses, COUNT still cycles 3..0.
- Abort/collision: PRESET=100, enable, clear EN at COUNT=40 -> COUNT holds 40, irq stays 0. CTRL write coinciding with INT entry -> flag cleared, write value kept.
- Async reset: assert reset=0 between clock edges while irq=1 -> irq=0 and COUNT=0 before the next clk edge.
- With TIMER_PRESCALE_EN: PRESCALE=1, PRESET=2, MODE0 -> COUNT decrements every 2 clocks; irq=1 after edge 8 instead of edge 4.
